ifetch_buffer: RTL
==================

# ifetch_buffer

Instruction fetch buffer that sits directly downstream of the PC register. It takes the current PC, issues one read at a time to instruction memory over a req/ack handshake, and queues returned {pc, instr} pairs in a small FIFO for the decode stage. It holds the PC register (drives its stall input) until each fetch is accepted. It also discards queued and in-flight instructions when a taken branch flushes the front end.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, 2..16.
- CW, $clog2(DEPTH)+1: width of the occupancy count.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  reset; synchronous, active-low.
- pc_in  in  32  current PC from the PC register.
- flush  in  1  taken branch; one-cycle pulse.
- stall_pc  out  1  to the PC register stall input; 1 holds the PC.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address.
- imem_ack  in  1  response valid; single-cycle pulse.
- imem_rdata  in  32  instruction word; valid when imem_ack=1.
- dec_valid  out  1  head entry valid.
- dec_ready  in  1  decode accepts head entry.
- dec_instr  out  32  head instruction.
- dec_pc  out  32  head PC.
- count  out  CW  FIFO occupancy.

## Operation
State machine with states IDLE, REQ and DROP.

- **IDLE**
  - If count < DEPTH and flush=0: register imem_addr <= pc_in and imem_req <= 1, then go to REQ.
  - Otherwise stay in IDLE with imem_req=0.
- **REQ**
  - imem_req and imem_addr stay stable until the ack arrives.
  - On imem_ack=1 with flush=0: push {imem_addr, imem_rdata}, drop imem_req, go to IDLE.
- **DROP**
  - Entered when flush=1 in REQ with imem_ack=0.
  - imem_req is dropped; the outstanding response is still owed.
  - The next imem_ack is discarded, then go to IDLE.
- **flush**
  - Occupancy is cleared to 0 and head/tail pointers reset on the same edge. dec_valid=0 on the next cycle.
  - flush with imem_ack in REQ: the response is discarded and the FSM goes to IDLE.
  - flush in IDLE: no request is issued that cycle.
- **stall_pc** is combinational: 0 iff (state==REQ & imem_ack & ~flush) | flush; otherwise 1.
  - The PC therefore advances exactly once per accepted fetch.
  - The PC takes the branch target on flush.
- **Pop:** dec_valid & dec_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Pop when full is legal. Push never overflows, because a slot is checked at issue and count cannot rise while REQ is outstanding.
- **Pointers** are log2(DEPTH) bits and wrap modulo DEPTH. count is the authoritative full/empty indicator.
- **dec_instr/dec_pc** show the head entry. They are don't-care when dec_valid=0 but must not be X after reset.

## Timing
- **Reset** (rst_n=0 at posedge): state=IDLE, imem_req=0, imem_addr=0, count=0, dec_valid=0, dec_instr=0, dec_pc=0, pointers=0. stall_pc=1 while in reset.
- **Reset mid-operation:** an ack arriving in the reset cycle is ignored. An ack arriving after reset, while the FSM is in IDLE, is ignored.
- **Issue:** imem_req rises 1 cycle after IDLE sees a free slot.
- **Latency:** ack at cycle N gives dec_valid=1 at N+1. Minimum ack-to-ack throughput is one fetch per 2 cycles, plus memory latency.
- **Ready:** dec_ready may toggle freely. The head entry is held stable while dec_valid=1 and dec_ready=0.
- **Flush precedence:** flush has priority over push, pop and issue in the same cycle.

## Configuration
- IFB_BYPASS_EN defined:
  - When count==0, the FSM is in REQ and imem_ack=1 (no flush), imem_rdata/imem_addr drive dec_instr/dec_pc combinationally and dec_valid=1 in the ack cycle.
  - If dec_ready=1 the entry is consumed and not pushed.
  - If dec_ready=0 it is pushed normally.
- Not defined: no combinational path from imem_* to dec_*. The minimum latency is 1 cycle as above.

## Test plan
- **Reset:** rst_n=0 for 2 cycles with imem_ack pulsed -> count=0, dec_valid=0, imem_req=0, stall_pc=1. After release, imem_req=1 with imem_addr=0x00400020 one cycle later.
- **Streaming:** memory acks 1 cycle after req with rdata=addr^0xA5A5A5A5, dec_ready=1 -> decode sees PCs 0x00400020, 0x00400024, 0x00400028… in order with matching instr. stall_pc=0 exactly in ack cycles.
- **Full:** dec_ready=0 -> count reaches DEPTH=4, imem_req stays 0 and stall_pc stays 1. One pop -> exactly one new fetch issues.
- **Flush while outstanding:** flush in REQ with ack delayed 3 cycles -> count=0, DROP entered, late ack discarded, next fetch uses the branch-target pc_in.
- **Simultaneous flush and ack:** flush and imem_ack in the same cycle with count=2 -> response dropped, count=0, dec_valid=0 the next cycle.
- **Bypass** (IFB_BYPASS_EN): empty FIFO, dec_ready=1, ack -> dec_valid=1 in the ack cycle and count stays 0. Without the macro, dec_valid=1 one cycle later.

Source files
------------

// File: rtl/ifetch_buffer.sv
// Instruction fetch buffer: one imem request at a time, {pc, instr} FIFO toward decode, flush handling.
// Define IFB_BYPASS_EN to present a response directly to decode, in its ack cycle, when the FIFO is empty.
module ifetch_buffer #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   pc_in,
  input  logic          flush,
  output logic          stall_pc,
  output logic          imem_req,
  output logic [31:0]   imem_addr,
  input  logic          imem_ack,
  input  logic [31:0]   imem_rdata,
  output logic          dec_valid,
  input  logic          dec_ready,
  output logic [31:0]   dec_instr,
  output logic [31:0]   dec_pc,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t        state;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic ack_ok;
  logic fifo_valid;
  logic push;
  logic pop;

  // A response is accepted only in REQ and only if no flush arrives with it.
  assign ack_ok     = (state == REQ) & imem_ack & ~flush;
  assign fifo_valid = (count != '0);
  assign pop        = fifo_valid & dec_ready & ~flush;

`ifdef IFB_BYPASS_EN
  logic bypass;
  assign bypass    = ack_ok & ~fifo_valid;
  assign push      = ack_ok & ~(bypass & dec_ready);
  assign dec_valid = fifo_valid | bypass;
  assign dec_instr = bypass ? imem_rdata : (fifo_valid ? instr_mem[rd_ptr] : '0);
  assign dec_pc    = bypass ? imem_addr  : (fifo_valid ? pc_mem[rd_ptr]    : '0);
`else
  assign push      = ack_ok;
  assign dec_valid = fifo_valid;
  assign dec_instr = fifo_valid ? instr_mem[rd_ptr] : '0;
  assign dec_pc    = fifo_valid ? pc_mem[rd_ptr]    : '0;
`endif

  // The PC advances on an accepted fetch and loads the branch target on flush.
  assign stall_pc = ~rst_n | ~(ack_ok | flush);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      if (flush) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: ;
        endcase
      end

      case (state)
        IDLE: begin
          if (!flush && (count < CW'(DEPTH))) begin
            imem_req  <= 1'b1;
            imem_addr <= pc_in;
            state     <= REQ;
          end
        end
        REQ: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= IDLE;
          end else if (flush) begin
            // The memory still owes this response; DROP swallows it.
            imem_req <= 1'b0;
            state    <= DROP;
          end
        end
        DROP: begin
          if (imem_ack) state <= IDLE;
        end
        default: begin
          imem_req <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; count gates every read, so stale entries never reach decode.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= imem_addr;
      instr_mem[wr_ptr] <= imem_rdata;
    end
  end

endmodule
